// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings carried on the 2-bit op port
//   - FSM state type (IDLE / CALC / FIX)
//   - default operand width and iteration counter width
package mdu_pkg;

   localparam int MDU_WIDTH = 32;
   localparam int MDU_CNT_W = 5;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: iteration datapath of the multiply/divide unit.
// Holds the 2*WIDTH accumulator and the registered second magnitude, and
// performs one shift-add (multiply) or restoring shift-subtract (divide)
// step per clock while step is high.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load           load accumulator = {0, mag_a} and latch mag_b
//   step           perform one iteration
//   is_div         1 = restoring divide step, 0 = shift-add multiply step
//   mag_a, mag_b   unsigned operand magnitudes (valid with load)
//   acc_hi, acc_lo accumulator halves: product {hi,lo} or {remainder,quotient}
module mdu_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] mag_a,
   input  logic [WIDTH-1:0] mag_b,
   output logic [WIDTH-1:0] acc_hi,
   output logic [WIDTH-1:0] acc_lo
);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;

   // Multiply: the multiplier sits in the low half and is consumed LSB first;
   // the partial sum needs one carry bit, which is shifted straight back in.
   // Divide: the dividend sits in the low half; each step shifts its MSB into
   // the partial remainder and the new quotient bit into the LSB.
   always_comb begin
      add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
      rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff    = rem_sh - {1'b0, b_q};
      acc_nxt = acc;
      if (is_div) begin
         if (!diff[WIDTH])
            acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         if (acc[0])
            acc_nxt = {add_sum, acc[WIDTH-1:1]};
         else
            acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         b_q <= '0;
      end else if (load) begin
         acc <= {{WIDTH{1'b0}}, mag_a};
         b_q <= mag_b;
      end else if (step) begin
         acc <= acc_nxt;
      end
   end

   assign acc_hi = acc[2*WIDTH-1:WIDTH];
   assign acc_lo = acc[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit producing a HI/LO pair.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        request an operation (accepted only in IDLE)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   src_a/src_b  multiplicand/dividend, multiplier/divisor (sampled with start)
//   busy         high while state != IDLE
//   done         one-cycle pulse when hi/lo take a new result
//   div_by_zero  updated with every done; 1 when a divide had src_b == 0
//   hi, lo       result pair, held between operations
//
// Handshake: start is taken on an edge where state is IDLE; op/src_a/src_b
// are registered on that edge (N) and ignored afterwards. busy stays high
// after edges N..N+32, done pulses after edge N+33 with hi/lo valid from then
// on. start while busy is dropped (no queuing); start in the done cycle is
// accepted since the FSM is already back in IDLE.
// The FSM state is kept in the signal 'state' for probing.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int CNT_W = MDU_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   count;
   logic               load;
   logic               step;

   logic [1:0]         op_q;
   logic               neg_a_q;
   logic               neg_b_q;
   logic               b_zero_q;
   logic [WIDTH-1:0]   src_a_q;

   logic               signed_op;
   logic               neg_a;
   logic               neg_b;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;

   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   // Operand conditioning: signed ops (op[0]==0) work on magnitudes.
   // Negating 0x80000000 yields 0x80000000, which is the correct unsigned
   // magnitude 2**31.
   always_comb begin
      signed_op = ~op[0];
      neg_a     = signed_op & src_a[WIDTH-1];
      neg_b     = signed_op & src_b[WIDTH-1];
      mag_a     = neg_a ? -src_a : src_a;
      mag_b     = neg_b ? -src_b : src_b;
   end

   mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .is_div (op_q[1]),
      .mag_a  (mag_a),
      .mag_b  (mag_b),
      .acc_hi (acc_hi),
      .acc_lo (acc_lo)
   );

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (count == LAST) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state != IDLE);
      load = (state == IDLE) && start;
      step = (state == CALC);
   end

   // Operation context captured at accept, iteration counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         b_zero_q <= 1'b0;
         src_a_q  <= '0;
         count    <= '0;
      end else if (load) begin
         op_q     <= op;
         neg_a_q  <= neg_a;
         neg_b_q  <= neg_b;
         b_zero_q <= (src_b == '0);
         src_a_q  <= src_a;
         count    <= '0;
      end else if (step) begin
         count    <= count + 1'b1;
      end
   end

   // Sign correction. The remainder follows the dividend's sign (truncating
   // division); the most-negative / -1 case wraps naturally to 0x80000000.
   always_comb begin
      prod   = {acc_hi, acc_lo};
      res_hi = acc_hi;
      res_lo = acc_lo;
      if (op_q[1]) begin
         if (b_zero_q) begin
            res_hi = src_a_q;
            res_lo = '1;
         end else begin
            res_lo = (neg_a_q ^ neg_b_q) ? -acc_lo : acc_lo;
            res_hi = neg_a_q ? -acc_hi : acc_hi;
         end
      end else begin
         if (neg_a_q ^ neg_b_q) prod = -prod;
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end
   end

   // Result registers: only written in FIX, otherwise held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= (state == FIX);
         if (state == FIX) begin
            hi          <= res_hi;
            lo          <= res_lo;
            div_by_zero <= op_q[1] & b_zero_q;
         end
      end
   end

endmodule
